// File: rtl/pipeline_sequencer_if.sv
// Pipeline hazard/status bundle between the datapath and the pipeline sequencer.
// The sequencer connects through the slave modport; the datapath drives through the master modport.
interface pipeline_sequencer_if #(
    parameter int unsigned CNT_W = 16
);
    logic [4:0]       Rd_ex;
    logic [4:0]       Rn_id;
    logic [4:0]       Rm_id;
    logic             memRead_ex;
    logic             branch_taken_mem;
    logic             mem_req;
    logic             mem_ready;

    logic             pc_en;
    logic             ifid_en;
    logic             idex_bubble;
    logic             pipe_hold;
    logic             memwb_bubble;
    logic             flush_if;
    logic             flush_id;
    logic             flush_ex;
    logic [1:0]       state;
    logic             mem_timeout;
    logic [CNT_W-1:0] stall_cycles;
    logic [CNT_W-1:0] flush_count;

    modport master (
        output Rd_ex, Rn_id, Rm_id, memRead_ex, branch_taken_mem, mem_req, mem_ready,
        input  pc_en, ifid_en, idex_bubble, pipe_hold, memwb_bubble,
               flush_if, flush_id, flush_ex, state, mem_timeout, stall_cycles, flush_count
    );

    modport slave (
        input  Rd_ex, Rn_id, Rm_id, memRead_ex, branch_taken_mem, mem_req, mem_ready,
        output pc_en, ifid_en, idex_bubble, pipe_hold, memwb_bubble,
               flush_if, flush_id, flush_ex, state, mem_timeout, stall_cycles, flush_count
    );
endinterface

// File: rtl/pipeline_sequencer.sv
// Pipeline sequencer: load-use stalls, branch flushes, memory-wait holds with timeout to HALT.
// Optional perf counters (stall_cycles, flush_count) enabled by PIPELINE_SEQ_PERF_EN.
module pipeline_sequencer #(
    parameter int unsigned MAX_WAIT = 15,
    parameter int unsigned CNT_W    = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    pipeline_sequencer_if.slave  seq
);
    localparam int unsigned WAIT_W = 8;
    localparam logic [4:0]  XZR    = 5'd31;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        HALT     = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [WAIT_W-1:0] wait_q, wait_d;

    logic hazard_c, mem_done_c, run_out_c, hold_out_c;
    logic pc_en_c, ifid_en_c, idex_bubble_c, flush_c;

    // XZR is hardwired zero, so a load targeting it never creates a dependency.
    assign hazard_c   = seq.memRead_ex && (seq.Rd_ex != XZR) &&
                        ((seq.Rd_ex == seq.Rn_id) || (seq.Rd_ex == seq.Rm_id));
    assign mem_done_c = seq.mem_req && seq.mem_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= RUN;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
        end
    end

    // Next state; memory wait outranks branch flush and load-use stall.
    always_comb begin
        state_d    = state_q;
        wait_d     = wait_q;
        run_out_c  = 1'b0;
        hold_out_c = 1'b0;
        case (state_q)
            RUN: begin
                if (seq.mem_req && !seq.mem_ready) begin
                    hold_out_c = 1'b1;
                    state_d    = MEM_WAIT;
                    wait_d     = WAIT_W'(1);
                end else begin
                    run_out_c = 1'b1;
                end
            end
            MEM_WAIT: begin
                if (!mem_done_c) begin
                    hold_out_c = 1'b1;
                    wait_d     = wait_q + WAIT_W'(1);
                    if ((32'(wait_q) + 32'd1) >= 32'(MAX_WAIT)) begin
                        state_d = HALT;
                    end
                end else begin
                    run_out_c = 1'b1;
                    state_d   = RUN;
                    wait_d    = '0;
                end
            end
            HALT: begin
                hold_out_c = 1'b1;
            end
            default: begin
                state_d = RUN;
                wait_d  = '0;
            end
        endcase
    end

    // Run-cycle outputs: flush beats load-use stall.
    always_comb begin
        pc_en_c       = 1'b0;
        ifid_en_c     = 1'b0;
        idex_bubble_c = 1'b0;
        flush_c       = 1'b0;
        if (run_out_c) begin
            if (seq.branch_taken_mem) begin
                pc_en_c = 1'b1;
                flush_c = 1'b1;
            end else if (hazard_c) begin
                idex_bubble_c = 1'b1;
            end else begin
                pc_en_c   = 1'b1;
                ifid_en_c = 1'b1;
            end
        end
    end

    assign seq.pc_en        = pc_en_c;
    assign seq.ifid_en      = ifid_en_c;
    assign seq.idex_bubble  = idex_bubble_c;
    assign seq.pipe_hold    = hold_out_c;
    assign seq.memwb_bubble = hold_out_c;
    assign seq.flush_if     = flush_c;
    assign seq.flush_id     = flush_c;
    assign seq.flush_ex     = flush_c;
    assign seq.state        = state_q;
    assign seq.mem_timeout  = (state_q == HALT);

`ifdef PIPELINE_SEQ_PERF_EN
    logic [CNT_W-1:0] stall_q, flush_q;

    // Saturating performance counters.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            if (!pc_en_c && (stall_q != '1)) begin
                stall_q <= stall_q + CNT_W'(1);
            end
            if (flush_c && (flush_q != '1)) begin
                flush_q <= flush_q + CNT_W'(1);
            end
        end
    end

    assign seq.stall_cycles = stall_q;
    assign seq.flush_count  = flush_q;
`else
    assign seq.stall_cycles = '0;
    assign seq.flush_count  = '0;
`endif
endmodule

// File: doc/pipeline_sequencer.md
PIPELINE_SEQUENCER -- requirements
Module: pipeline_sequencer

Interface
REQ-001 Parameter: MAX_WAIT, default 15, memory wait cycles allowed before timeout (range 2..255).
REQ-002 Parameter: CNT_W, default 16, width of performance counters.
REQ-003 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port: reset_n  input  1  asynchronous, active-low reset.
REQ-005 Port: Rd_ex  input  5  destination register of the EX-stage instruction.
REQ-006 Port: Rn_id, Rm_id  input  5 each  source registers of the ID-stage instruction.
REQ-007 Port: memRead_ex  input  1  EX-stage instruction is a load.
REQ-008 Port: branch_taken_mem  input  1  taken branch resolved in MEM this cycle.
REQ-009 Port: mem_req, mem_ready  input  1 each  MEM-stage data access active; data memory completes access this cycle.
REQ-010 Port: pc_en, ifid_en  output  1 each  PC and IF/ID register may update.
REQ-011 Port: idex_bubble  output  1  load ID/EX with zero control lines.
REQ-012 Port: pipe_hold  output  1  hold ID/EX and EX/MEM contents.
REQ-013 Port: memwb_bubble  output  1  load MEM/WB with zero control lines.
REQ-014 Port: flush_if, flush_id, flush_ex  output  1 each  squash the IF/ID, ID/EX, EX/MEM contents.
REQ-015 Port: state  output  2  current state: RUN=0, MEM_WAIT=1, HALT=2.
REQ-016 Port: mem_timeout  output  1  sticky timeout flag.
REQ-017 Port: stall_cycles, flush_count  output  CNT_W each  performance counters.

Function
REQ-018 Load-use hazard SHALL be memRead_ex & (Rd_ex != 31) & (Rd_ex == Rn_id | Rd_ex == Rm_id); register 31 (XZR) never stalls.
REQ-019 Outputs SHALL be combinational on state and inputs; all are 0 except pc_en = ifid_en = 1 when RUN with no event.
REQ-020 RUN, load-use hazard, no branch: pc_en = ifid_en = 0, idex_bubble = 1 for that cycle only; state stays RUN.
REQ-021 RUN, branch_taken_mem = 1, no memory wait: flush_if = flush_id = flush_ex = 1, pc_en = 1; the flush overrides the load-use stall (idex_bubble = 0).
REQ-022 RUN, mem_req = 1 and mem_ready = 0: pc_en = ifid_en = 0, pipe_hold = 1, memwb_bubble = 1; next state MEM_WAIT; wait counter = 1.
REQ-023 MEM_WAIT, mem_ready = 0: same outputs as REQ-022; wait counter increments; at wait counter == MAX_WAIT, next state is HALT.
REQ-024 MEM_WAIT, mem_ready = 1: outputs as in RUN for that cycle (including flush if branch_taken_mem = 1, stall if hazard); next state RUN; wait counter cleared.
REQ-025 When mem_req and branch_taken_mem are both 1, the memory wait SHALL take priority; the flush is issued in the cycle mem_ready = 1.
REQ-026 HALT: pc_en = ifid_en = 0, pipe_hold = 1, memwb_bubble = 1, mem_timeout = 1; exit only by reset.
REQ-027 mem_ready = 1 with mem_req = 0 SHALL be ignored.

Reset
REQ-028 reset_n = 0 SHALL immediately force state = RUN, wait counter = 0, mem_timeout = 0, and counters = 0, independent of clk.
REQ-029 Reset asserted in MEM_WAIT or HALT SHALL abandon the access; the first cycle after release behaves as RUN.

Configuration
REQ-030 Macro PIPELINE_SEQ_PERF_EN defined: stall_cycles increments each cycle pc_en = 0; flush_count increments each cycle flush_if = 1; both saturate at all-ones.
REQ-031 Macro PIPELINE_SEQ_PERF_EN undefined: the counters SHALL be absent; stall_cycles and flush_count are tied to 0 and the port list is unchanged.

Verification
REQ-032 Load-use: memRead_ex = 1, Rd_ex = 5, Rn_id = 5 -> one cycle with pc_en = 0, idex_bubble = 1; the next cycle with memRead_ex = 0 -> pc_en = 1.
REQ-033 XZR: memRead_ex = 1, Rd_ex = 31, Rm_id = 31 -> pc_en = 1, idex_bubble = 0.
REQ-034 Memory wait: mem_req = 1, mem_ready low for 3 cycles then high -> state = 1 for 3 cycles, pipe_hold = 1, then state = 0; stall_cycles = 3 with the macro defined.
REQ-035 Timeout with MAX_WAIT = 4: mem_ready never high -> state = 2 and mem_timeout = 1 after 4 wait cycles; reset_n low -> state = 0 and mem_timeout = 0 without a clock edge.
REQ-036 Branch during wait: mem_req = 1 and branch_taken_mem = 1, mem_ready high on the 2nd cycle -> no flush in the 1st cycle; flush_if/id/ex = 1 in the 2nd cycle; flush_count = 1.
REQ-037 Branch plus hazard: branch_taken_mem = 1 with load-use true -> flush all = 1, idex_bubble = 0, pc_en = 1.
